// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
// Load/store initiator between the execute stage and a word-organised data
// memory with a 1-cycle registered read path and per-byte write masks.
// Accepts one B/H/W request at a time, splits word-crossing accesses into
// two beats, reassembles load data and sign/zero-extends it.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   req_valid/req_ready request handshake; ready only in IDLE
//   req_addr/req_wdata  byte address, right-aligned store data
//   req_memOp/req_we    0=B 1=H 2=W 4=BU 5=HU (3,6,7 -> W); 1=store
//   resp_valid/rdata    one-cycle completion pulse, extended load data
//   busy                high outside IDLE
//   mem_*               word-aligned beat address, lane data, mask, strobes
//   mem_rdata           read word, valid the cycle after mem_re
//
// state  | meaning
// IDLE   | waiting for a request
// BEAT0  | beat 0 on the memory bus at the base word
// BEAT1  | beat 1 at base+4; loads capture beat-0 read data
// WAIT   | last read word arrives; load result is formed
// DONE   | resp_valid pulse
module lsu_mem_initiator #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [addrWidth-1:0] req_addr,
  input  logic [dataWidth-1:0] req_wdata,
  input  logic [2:0]           req_memOp,
  input  logic                 req_we,
  output logic                 resp_valid,
  output logic [dataWidth-1:0] resp_rdata,
  output logic                 busy,
  output logic [addrWidth-1:0] mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
  output logic [3:0]           mem_wmask,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [dataWidth-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_WAIT, S_DONE} state_t;

  state_t state, state_d;

  logic [addrWidth-1:0] addr_q;
  logic [dataWidth-1:0] wdata_q, w0_q;
  logic [2:0]           op_q;
  logic                 we_q;

  logic accept;
  assign req_ready = (state == S_IDLE) & ~rst;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;

  // Beat 0 is launched on the accept edge, so in IDLE the request fields
  // come straight from the inputs; afterwards from the latched copy.
  logic [addrWidth-1:0] cur_addr;
  logic [dataWidth-1:0] cur_wdata;
  logic [2:0]           cur_op;
  logic                 cur_we;

  always_comb begin
    if (state == S_IDLE) begin
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_op    = req_memOp;
      cur_we    = req_we;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_op    = op_q;
      cur_we    = we_q;
    end
  end

  logic [2:0] size;
  logic [3:0] smask;
  logic       ld_signed;

  always_comb begin
    case (cur_op)
      3'd0, 3'd4: begin size = 3'd1; smask = 4'b0001; end
      3'd1, 3'd5: begin size = 3'd2; smask = 4'b0011; end
      default:    begin size = 3'd4; smask = 4'b1111; end
    endcase
    ld_signed = (cur_op == 3'd0) | (cur_op == 3'd1);
  end

  logic [1:0]           off;
  logic                 split;
  logic [5:0]           sh0, sh1;
  logic [addrWidth-1:0] base, base1;
  logic [3:0]           mask0, mask1;
  logic [dataWidth-1:0] data0, data1;

  assign off   = cur_addr[1:0];
  assign split = ({1'b0, off} + size) > 3'd4;
  assign sh0   = {1'b0, off, 3'b000};
  assign sh1   = 6'd32 - sh0;
  assign base  = {cur_addr[addrWidth-1:2], 2'b00};
  assign base1 = base + addrWidth'(4);   // wraps past the top of memory
  assign mask0 = smask << off;
  assign mask1 = smask >> (3'd4 - {1'b0, off});
  assign data0 = cur_wdata << sh0;
  assign data1 = cur_wdata >> sh1;     // only used when split, so off != 0

  // In WAIT the arriving word is beat 0 for aligned loads, beat 1 for split.
  logic [dataWidth-1:0] w0_sel, w1_sel, v, ld_ext;
  assign w0_sel = split ? w0_q : mem_rdata;
  assign w1_sel = split ? mem_rdata : '0;
  assign v      = dataWidth'({w1_sel, w0_sel} >> sh0);

  always_comb begin
    case (size)
      3'd1:    ld_ext = ld_signed ? {{24{v[7]}}, v[7:0]}   : {24'b0, v[7:0]};
      3'd2:    ld_ext = ld_signed ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
      default: ld_ext = v;
    endcase
  end

  logic                 mem_re_d, mem_we_d, resp_valid_d;
  logic [3:0]           mem_wmask_d;
  logic [addrWidth-1:0] mem_addr_d;
  logic [dataWidth-1:0] mem_wdata_d, resp_rdata_d;

  always_comb begin
    state_d      = state;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wmask_d  = 4'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_BEAT0;
          mem_addr_d = base;
          mem_re_d   = ~cur_we;
          mem_we_d   = cur_we;
          if (cur_we) begin
            mem_wmask_d = mask0;
            mem_wdata_d = data0;
          end
        end
      end
      S_BEAT0: begin
        if (split) begin
          state_d    = S_BEAT1;
          mem_addr_d = base1;
          mem_re_d   = ~cur_we;
          mem_we_d   = cur_we;
          if (cur_we) begin
            mem_wmask_d = mask1;
            mem_wdata_d = data1;
          end
        end else if (cur_we) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_BEAT1: begin
        if (cur_we) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_ext;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      we_q       <= 1'b0;
      w0_q       <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wmask  <= 4'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        op_q    <= req_memOp;
        we_q    <= req_we;
      end
      if (state == S_BEAT1) begin
        w0_q <= mem_rdata;
      end
      mem_re     <= mem_re_d;
      mem_we     <= mem_we_d;
      mem_wmask  <= mem_wmask_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_memOp = '0;
  logic        req_we = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_memOp(req_memOp), .req_we(req_we),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // Memory: 256 words indexed by addr[9:2]; registered read, byte-masked write.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  int          nb, lat;
  logic [31:0] b_addr [2];
  logic [3:0]  b_mask [2];
  logic [31:0] b_data [2];
  logic [31:0] rdata_got;

  // Behavioural reference: byte-addressed memory view.
  function automatic int size_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[9:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < size_of(op); i++) v[8*i +: 8] = ref_byte(a + 32'(i));
    if (op == 3'd0 && v[7])  v[31:8]  = '1;
    if (op == 3'd1 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    logic [31:0] ba;
    for (int i = 0; i < size_of(op); i++) begin
      ba = a + 32'(i);
      ref_mem[ba[9:2]][8*ba[1:0] +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = a[9:2]; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[a[9:2]] = d;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic we, input logic hold);
    logic [31:0] first_w, last_w, exp_rdata;
    int exp_nb, exp_lat, bad;
    first_w = a & ~32'd3;
    last_w  = (a + 32'(size_of(op)) - 32'd1) & ~32'd3;
    exp_nb  = (first_w != last_w) ? 2 : 1;
    exp_lat = we ? 1 + exp_nb : 2 + exp_nb;
    exp_rdata = we ? 32'd0 : ref_load(a, op);
    if (we) ref_store(a, d, op);

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_req addr=%h ready=%b resp_valid=%b want 1/0", a, req_ready, resp_valid);
    end
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_memOp = op; req_we = we;
    @(posedge clk);
    #1;
    if (hold) begin
      req_addr = $urandom; req_wdata = $urandom; req_memOp = 3'($urandom); req_we = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    nb = 0; lat = 0; rdata_got = '0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_window addr=%h cyc=%0d ready=%b busy=%b want 0/1", a, n, req_ready, busy);
      end
      checks++;
      if ((mem_re && mem_we) || (!mem_we && mem_wmask != 4'b0) ||
          ((mem_re || mem_we) && (mem_addr[1:0] != 2'b0 || mem_we !== we))) begin
        errors++;
        $display("FAIL strobes addr=%h cyc=%0d re=%b we=%b mask=%b maddr=%h", a, n, mem_re, mem_we, mem_wmask, mem_addr);
      end
      if (mem_re || mem_we) begin
        if (nb < 2) begin
          b_addr[nb] = mem_addr; b_mask[nb] = mem_wmask; b_data[nb] = mem_wdata;
        end
        nb++;
      end
      if (resp_valid === 1'b1) begin
        lat = n;
        rdata_got = resp_rdata;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL resp_timeout addr=%h got none want latency %0d", a, exp_lat);
    end else if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h got=%0d want=%0d", a, lat, exp_lat);
    end
    checks++;
    if (nb != exp_nb || b_addr[0] !== first_w || (exp_nb == 2 && b_addr[1] !== last_w)) begin
      errors++;
      $display("FAIL beats addr=%h got n=%0d a0=%h a1=%h want n=%0d a0=%h a1=%h",
               a, nb, b_addr[0], b_addr[1], exp_nb, first_w, last_w);
    end
    checks++;
    if (rdata_got !== exp_rdata) begin
      errors++;
      $display("FAIL resp_rdata addr=%h op=%0d got=%h want=%h", a, op, rdata_got, exp_rdata);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL memory_image addr=%h got %0d differing words want 0", a, bad);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || mem_wmask !== 4'b0 || mem_addr !== 32'b0 || mem_wdata !== 32'b0 ||
        resp_rdata !== 32'b0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b busy=%b rv=%b re=%b we=%b mask=%b addr=%h want all 0",
               req_ready, busy, resp_valid, mem_re, mem_we, mem_wmask, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready got ready=%b busy=%b want 1/0", req_ready, busy);
    end
  endtask

  task automatic test_aligned_load();
    preload(32'h100, 32'hDEADBEEF);
    do_op(32'h100, 32'h0, 3'd2, 1'b0, 1'b0);
    checks++;
    if (rdata_got !== 32'hDEADBEEF || lat != 3 || b_addr[0] !== 32'h100) begin
      errors++;
      $display("FAIL lw_aligned got=%h lat=%0d a=%h want DEADBEEF 3 100", rdata_got, lat, b_addr[0]);
    end
  endtask

  task automatic test_sub_word_loads();
    preload(32'h100, 32'h80112233);
    do_op(32'h103, 32'h0, 3'd0, 1'b0, 1'b0);
    checks++;
    if (rdata_got !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb got=%h want FFFFFF80", rdata_got);
    end
    do_op(32'h103, 32'h0, 3'd4, 1'b0, 1'b0);
    checks++;
    if (rdata_got !== 32'h00000080) begin
      errors++; $display("FAIL lbu got=%h want 00000080", rdata_got);
    end
    do_op(32'h102, 32'h0, 3'd1, 1'b0, 1'b0);
    checks++;
    if (rdata_got !== 32'hFFFF8011) begin
      errors++; $display("FAIL lh got=%h want FFFF8011", rdata_got);
    end
  endtask

  task automatic test_split_load();
    preload(32'h100, 32'h44332211);
    preload(32'h104, 32'h88776655);
    do_op(32'h102, 32'h0, 3'd2, 1'b0, 1'b0);
    checks++;
    if (rdata_got !== 32'h66554433 || lat != 4 || b_addr[0] !== 32'h100 || b_addr[1] !== 32'h104) begin
      errors++;
      $display("FAIL lw_split got=%h lat=%0d a0=%h a1=%h want 66554433 4 100 104",
               rdata_got, lat, b_addr[0], b_addr[1]);
    end
  endtask

  task automatic test_stores();
    do_op(32'h103, 32'h0000ABCD, 3'd1, 1'b1, 1'b0);
    checks++;
    if (b_addr[0] !== 32'h100 || b_mask[0] !== 4'b1000 || b_data[0] !== 32'hCD000000 ||
        b_addr[1] !== 32'h104 || b_mask[1] !== 4'b0001 || b_data[1] !== 32'h000000AB || lat != 3) begin
      errors++;
      $display("FAIL sh_split got %h/%b/%h %h/%b/%h lat=%0d want 100/1000/CD000000 104/0001/000000AB 3",
               b_addr[0], b_mask[0], b_data[0], b_addr[1], b_mask[1], b_data[1], lat);
    end
    do_op(32'h101, 32'h000000FF, 3'd0, 1'b1, 1'b0);
    checks++;
    if (b_mask[0] !== 4'b0010 || b_data[0] !== 32'h0000FF00 || lat != 2) begin
      errors++;
      $display("FAIL sb_aligned got mask=%b data=%h lat=%0d want 0010 0000FF00 2", b_mask[0], b_data[0], lat);
    end
  endtask

  task automatic test_wrap();
    preload(32'hFFFFFFFC, 32'hA1B2C3D4);
    preload(32'h00000000, 32'h11223344);
    do_op(32'hFFFFFFFE, 32'h0, 3'd2, 1'b0, 1'b0);
    checks++;
    if (rdata_got !== 32'h3344A1B2 || b_addr[0] !== 32'hFFFFFFFC || b_addr[1] !== 32'h0) begin
      errors++;
      $display("FAIL lw_wrap got=%h a0=%h a1=%h want 3344A1B2 FFFFFFFC 00000000", rdata_got, b_addr[0], b_addr[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 128; i++) preload(32'h200 + 32'(4*i), $urandom);
    for (int i = 0; i < 60; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 255));
      do_op(a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_split();
    preload(32'h100, 32'h11223344);
    preload(32'h104, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h101; req_wdata = 32'hA1B2C3D4; req_memOp = 3'd2; req_we = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h104) begin
      errors++;
      $display("FAIL sw_split_beat1 got we=%b addr=%h want 1 104", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || mem_wmask !== 4'b0 || mem_addr !== 32'b0 || mem_wdata !== 32'b0 ||
        resp_rdata !== 32'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs ready=%b busy=%b rv=%b re=%b we=%b mask=%b addr=%h want all 0",
               req_ready, busy, resp_valid, mem_re, mem_we, mem_wmask, mem_addr);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL midop_no_resp cyc=%0d got=%b want 0", n, resp_valid);
      end
    end
    ref_mem[8'h40] = 32'hB2C3D444;
    checks++;
    if (mem[8'h40] !== 32'hB2C3D444 || mem[8'h41] !== 32'h55667788) begin
      errors++;
      $display("FAIL partial_write got %h %h want B2C3D444 55667788", mem[8'h40], mem[8'h41]);
    end
    rst = 1'b0;
    do_op(32'h100, 32'h0, 3'd2, 1'b0, 1'b0);
    do_op(32'h104, 32'h0, 3'd2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_sub_word_loads();
    test_split_load();
    test_stores();
    test_wrap();
    test_random();
    test_reset_mid_split();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that sits between the CPU execute stage and a word-organised data memory.
- The data memory has a registered read path (1-cycle read latency) and per-byte write masks.
- The block accepts one byte, halfword or word request at a time and drives word-aligned memory beats.
- A misaligned access that crosses a word boundary is split into two beats. Load data is reassembled, then sign- or zero-extended before it is returned.

Parameters:
- addrWidth, 32, request and memory address width.
- dataWidth, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  addrWidth  byte address.
- req_wdata  in  dataWidth  store data, right-aligned.
- req_memOp  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU. Codes 3, 6, 7 are treated as W.
- req_we  in  1  1=store, 0=load.
- resp_valid  out  1  one-cycle completion pulse, for both loads and stores.
- resp_rdata  out  dataWidth  extended load result, valid with resp_valid. 0 for stores.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  addrWidth  word-aligned beat address; bits [1:0] are always 0.
- mem_wdata  out  dataWidth  lane-aligned store data.
- mem_wmask  out  4  byte-lane write enables.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_rdata  in  dataWidth  word read; valid in the cycle after mem_re.

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - All registered outputs = 0, including resp_valid, mem_re, mem_we, mem_wmask, mem_addr, mem_wdata and resp_rdata.
  - req_ready = (state==IDLE) & ~rst, so it is 0 while rst is asserted.
- Accept: a request is taken when req_valid & req_ready at a rising edge.
  - addr, wdata, memOp and we are latched.
  - req_valid held while busy is ignored; there is no queueing.
- Derived fields:
  - off = addr[1:0]; size = 1, 2 or 4 bytes.
  - split = (off + size > 4).
  - base = {addr[31:2], 2'b00}.
  - base1 = base + 4, mod 2^32, so it wraps to 0.
- States:
  - IDLE -> BEAT0 on accept.
  - BEAT0: drive beat 0 at base. If split -> BEAT1; else load -> WAIT, store -> DONE.
  - BEAT1: drive beat 1 at base1. A load also captures beat-0 data. Then load -> WAIT, store -> DONE.
  - WAIT: capture the last beat's mem_rdata -> DONE.
  - DONE: resp_valid = 1 for exactly one cycle -> IDLE. The next accept can occur in the cycle after DONE.
- Strobes:
  - mem_re / mem_we are asserted only in BEAT0 or BEAT1, never both at once.
  - mem_wmask = 0 when mem_we = 0.
- Latency from the accept edge to resp_valid:
  - aligned load: 3 cycles.
  - split load: 4 cycles.
  - aligned store: 2 cycles.
  - split store: 3 cycles.
- Store lanes, with smask = 0001 (B), 0011 (H) or 1111 (W):
  - beat0 mask = (smask << off) & 4'hF; beat0 data = wdata << 8*off, truncated to 32 bits.
  - beat1 mask = smask >> (4-off); beat1 data = wdata >> 8*(4-off).
- Load assembly:
  - v = ({w1, w0} >> 8*off)[31:0], with w1 = 0 when not split.
  - B: sign-extend v[7:0]. BU: zero-extend v[7:0].
  - H: sign-extend v[15:0]. HU: zero-extend v[15:0].
  - W: v.
- Reset mid-operation:
  - The transaction is abandoned and no resp_valid is produced.
  - If beat 0 of a split store was already issued, it stays committed. This partial write is accepted behaviour.

Test Plan:
- Aligned LW 0x100, mem[0x100] = 0xDEADBEEF -> one mem_re with mem_addr 0x100; resp_valid 3 cycles after accept; resp_rdata 0xDEADBEEF; req_ready low throughout.
- LB at 0x103 with mem[0x100] = 0x80112233 -> resp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF8011.
- Split LW at 0x102, mem[0x100] = 0x44332211 and mem[0x104] = 0x88776655 -> reads at 0x100 then 0x104 in consecutive cycles; resp_rdata 0x66554433 after 4 cycles.
- Split SH at 0x103, wdata 0x0000ABCD:
  - beat0: addr 0x100, mask 1000, data 0xCD000000.
  - beat1: addr 0x104, mask 0001, data 0x000000AB.
  - resp_valid after 3 cycles.
  - Aligned SB at 0x101, wdata 0xFF -> mask 0010, data 0x0000FF00.
- Wrap: LW at 0xFFFFFFFE -> beats 0xFFFFFFFC then 0x00000000; assembled result = {mem[0][15:0], mem[0xFFFFFFFC][31:16]}.
- Reset asserted during BEAT1 of a split SW at 0x101:
  - all outputs 0 immediately; no resp_valid.
  - mem[0x100] holds the beat-0 bytes; mem[0x104] is unchanged.
  - after reset deasserts, a back-to-back LW is accepted with the IDLE-state latency.
